apu_frame_sequencer: RTL

//  NES APU frame sequencer: divides the CPU-cycle enable into quarter-/half-frame strobes.

---
 rtl/apu_pkg.sv | 41 ++++
 rtl/frame_step_timer.sv | 32 +++
 rtl/apu_frame_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
// apu_pkg: mode constants, step action codes, per-mode step tables and the
// NTSC/PAL step periods for the APU frame sequencer.
package apu_pkg;

  localparam logic MODE_4STEP = 1'b0;
  localparam logic MODE_5STEP = 1'b1;

  localparam int NTSC_STEP_PERIOD = 7457;
  localparam int PAL_STEP_PERIOD  = 8313;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_Q    = 2'd1,
    STEP_QH   = 2'd2
  } step_action_t;

  typedef enum logic [2:0] {
    ST_S0 = 3'd0,
    ST_S1 = 3'd1,
    ST_S2 = 3'd2,
    ST_S3 = 3'd3,
    ST_S4 = 3'd4
  } step_t;

  // Padded to 8 entries so any 3-bit step value indexes safely.
  localparam step_action_t ACT_4STEP [8] = '{
    STEP_Q, STEP_QH, STEP_Q, STEP_QH, STEP_NONE, STEP_NONE, STEP_NONE, STEP_NONE
  };
  localparam step_action_t ACT_5STEP [8] = '{
    STEP_Q, STEP_QH, STEP_Q, STEP_NONE, STEP_QH, STEP_NONE, STEP_NONE, STEP_NONE
  };

  function automatic step_action_t step_action(input logic mode, input step_t step);
    return (mode == MODE_5STEP) ? ACT_5STEP[step] : ACT_4STEP[step];
  endfunction

  function automatic step_t last_step(input logic mode);
    return (mode == MODE_5STEP) ? ST_S4 : ST_S3;
  endfunction

endpackage

// File: rtl/frame_step_timer.sv
// frame_step_timer: prescale counter; counts iTick and flags the tick that
// completes a sequencer step. iClear restarts the count and masks that completion.
module frame_step_timer #(
  parameter int STEP_PERIOD = 7457,
  parameter int CNT_WIDTH   = 15
) (
  input  logic iClk,
  input  logic iReset_n,
  input  logic iTick,
  input  logic iClear,
  output logic oStep_done
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STEP_PERIOD - 1);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_wrap;

  assign w_wrap     = iTick && (r_cnt == LAST_CNT);
  assign oStep_done = w_wrap && !iClear;

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_cnt <= '0;
    end else if (iClear || w_wrap) begin
      r_cnt <= '0;
    end else if (iTick) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: NES APU frame sequencer producing quarter/half-frame strobes and the frame IRQ.
// Build option FRAME_SEQ_WRITE_DELAY_EN: a $4017 write takes effect on the 3rd iTick after it.
//
//  state | meaning
//  ST_S0 | waiting for step 0 completion (Q)
//  ST_S1 | waiting for step 1 completion (Q+H)
//  ST_S2 | waiting for step 2 completion (Q)
//  ST_S3 | step 3: 4-step Q+H and IRQ, 5-step no action
//  ST_S4 | step 4, 5-step only (Q+H)
import apu_pkg::*;

module apu_frame_sequencer #(
  parameter int STEP_PERIOD = NTSC_STEP_PERIOD,
  parameter int CNT_WIDTH   = 15
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iTick,
  input  logic       iWrite,
  input  logic       iMode,
  input  logic       iIrq_inhibit,
  input  logic       iIrq_ack,
  output logic       oQuarter_clk,
  output logic       oHalf_clk,
  output logic       oIrq,
  output logic [2:0] oStep
);

  step_t        r_step;
  logic         r_mode;
  logic         r_inhibit;
  logic         r_irq;
  logic         r_quarter;
  logic         r_half;

  logic         w_step_done;
  logic         w_wr_apply;
  logic         w_wr_mode;
  logic         w_wr_inh;
  logic         w_irq_set;
  step_action_t w_action;
  step_t        w_next_step;

`ifdef FRAME_SEQ_WRITE_DELAY_EN
  logic       r_pend;
  logic       r_pend_mode;
  logic       r_pend_inh;
  logic [1:0] r_pend_cnt;

  // A fresh write in the same cycle restarts the window instead of applying the old one.
  assign w_wr_apply = r_pend && iTick && !iWrite && (r_pend_cnt == 2'd2);
  assign w_wr_mode  = r_pend_mode;
  assign w_wr_inh   = r_pend_inh;

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_pend      <= 1'b0;
      r_pend_mode <= MODE_4STEP;
      r_pend_inh  <= 1'b0;
      r_pend_cnt  <= 2'd0;
    end else if (iWrite) begin
      r_pend      <= 1'b1;
      r_pend_mode <= iMode;
      r_pend_inh  <= iIrq_inhibit;
      r_pend_cnt  <= 2'd0;
    end else if (w_wr_apply) begin
      r_pend      <= 1'b0;
      r_pend_cnt  <= 2'd0;
    end else if (r_pend && iTick) begin
      r_pend_cnt  <= r_pend_cnt + 2'd1;
    end
  end
`else
  assign w_wr_apply = iWrite;
  assign w_wr_mode  = iMode;
  assign w_wr_inh   = iIrq_inhibit;
`endif

  frame_step_timer #(
    .STEP_PERIOD (STEP_PERIOD),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_timer (
    .iClk       (iClk),
    .iReset_n   (iReset_n),
    .iTick      (iTick),
    .iClear     (w_wr_apply),
    .oStep_done (w_step_done)
  );

  assign w_action    = step_action(r_mode, r_step);
  assign w_next_step = (r_step == last_step(r_mode)) ? ST_S0 : step_t'(r_step + 3'd1);
  assign w_irq_set   = w_step_done && (r_mode == MODE_4STEP) && (r_step == ST_S3) && !r_inhibit;

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_step    <= ST_S0;
      r_mode    <= MODE_4STEP;
      r_inhibit <= 1'b0;
      r_irq     <= 1'b0;
      r_quarter <= 1'b0;
      r_half    <= 1'b0;
    end else if (w_wr_apply) begin
      r_step    <= ST_S0;
      r_mode    <= w_wr_mode;
      r_inhibit <= w_wr_inh;
      r_quarter <= (w_wr_mode == MODE_5STEP);
      r_half    <= (w_wr_mode == MODE_5STEP);
      if (w_wr_inh || iIrq_ack) begin
        r_irq <= 1'b0;
      end
    end else begin
      r_quarter <= w_step_done && (w_action != STEP_NONE);
      r_half    <= w_step_done && (w_action == STEP_QH);
      if (w_step_done) begin
        r_step <= w_next_step;
      end
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (iIrq_ack) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign oQuarter_clk = r_quarter;
  assign oHalf_clk    = r_half;
  assign oIrq         = r_irq;
  assign oStep        = r_step;

endmodule
